// File: rtl/mult_add_pkg.sv
// Shared constants for the signed multiply-add datapath and its downstream stats blocks.
package mult_add_pkg;

   localparam int unsigned DATA_W = 8;

   localparam logic signed [DATA_W-1:0] SMIN = -8'sd128;
   localparam logic signed [DATA_W-1:0] SMAX = 8'sd127;

   // Width of a sum of 2^log2n samples of data_w bits that can never overflow.
   function automatic int unsigned sum_w(input int unsigned data_w, input int unsigned log2n);
      return data_w + log2n;
   endfunction

endpackage

// File: rtl/win_minmax.sv
// Running signed min/max over a window, with clear and update enables.
module win_minmax import mult_add_pkg::*; #(
   parameter int unsigned W = mult_add_pkg::DATA_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                upd,
   input  logic signed [W-1:0] d,
   output logic signed [W-1:0] mn,
   output logic signed [W-1:0] mx,
   output logic signed [W-1:0] nxt_mn_c,
   output logic signed [W-1:0] nxt_mx_c
);

   localparam logic signed [W-1:0] POS_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] NEG_MAX = {1'b1, {(W-1){1'b0}}};

   // Values the registers would take with this edge's sample folded in.
   always_comb begin
      nxt_mn_c = mn;
      nxt_mx_c = mx;
      if (upd) begin
         if (d < mn) nxt_mn_c = d;
         if (d > mx) nxt_mx_c = d;
      end
   end

   // Clear wins over update so a closing sample never leaks into the next window.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         mn <= POS_MAX;
         mx <= NEG_MAX;
      end else begin
         mn <= nxt_mn_c;
         mx <= nxt_mx_c;
      end
   end

endmodule

// File: rtl/mult_add_win_stats.sv
// Windowed sum/mean/min/max over the multiply-add result stream, with early flush.
module mult_add_win_stats import mult_add_pkg::*; #(
   parameter int unsigned DATA_W = mult_add_pkg::DATA_W,
   parameter int unsigned LOG2N  = 3
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic signed [DATA_W-1:0]                   din,
   input  logic                                       din_val,
   input  logic                                       flush,
   output logic signed [sum_w(DATA_W, LOG2N)-1:0]     sum_out,
   output logic signed [DATA_W-1:0]                   avg_out,
   output logic signed [DATA_W-1:0]                   min_out,
   output logic signed [DATA_W-1:0]                   max_out,
   output logic        [LOG2N:0]                      cnt_out,
   output logic                                       partial,
   output logic                                       val_out
);

   localparam int unsigned SW = sum_w(DATA_W, LOG2N);
   localparam int unsigned CW = LOG2N + 1;
   localparam int unsigned N  = 1 << LOG2N;

   logic signed [SW-1:0]     acc, acc_nxt_c;
   logic        [CW-1:0]     cnt, cnt_nxt_c;
   logic signed [DATA_W-1:0] mn, mx, mn_nxt_c, mx_nxt_c;
   logic                     close_c;

   always_comb begin
      acc_nxt_c = acc;
      cnt_nxt_c = cnt;
      if (din_val) begin
         acc_nxt_c = acc + {{LOG2N{din[DATA_W-1]}}, din};
         cnt_nxt_c = cnt + CW'(1);
      end
      close_c = (din_val && (cnt == CW'(N - 1))) || (flush && (cnt_nxt_c != '0));
   end

   win_minmax #(.W(DATA_W)) u_minmax (
      .clk      (clk),
      .rst      (rst),
      .clr      (close_c),
      .upd      (din_val),
      .d        (din),
      .mn       (mn),
      .mx       (mx),
      .nxt_mn_c (mn_nxt_c),
      .nxt_mx_c (mx_nxt_c)
   );

   // Accumulator/counter restart on the closing edge; results are held until the next close.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc     <= '0;
         cnt     <= '0;
         sum_out <= '0;
         avg_out <= '0;
         min_out <= '0;
         max_out <= '0;
         cnt_out <= '0;
         partial <= 1'b0;
         val_out <= 1'b0;
      end else if (close_c) begin
         acc     <= '0;
         cnt     <= '0;
         sum_out <= acc_nxt_c;
         avg_out <= DATA_W'(acc_nxt_c >>> LOG2N);
         min_out <= mn_nxt_c;
         max_out <= mx_nxt_c;
         cnt_out <= cnt_nxt_c;
         partial <= (cnt_nxt_c < CW'(N));
         val_out <= 1'b1;
      end else begin
         acc     <= acc_nxt_c;
         cnt     <= cnt_nxt_c;
         val_out <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mult_add_win_stats.sv
// Directed bench for mult_add_win_stats with LOG2N=2 (window of 4).
module tb_mult_add_win_stats;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned LOG2N  = 2;

   logic                        clk;
   logic                        rst;
   logic signed [DATA_W-1:0]    din;
   logic                        din_val;
   logic                        flush;
   logic signed [DATA_W+LOG2N-1:0] sum_out;
   logic signed [DATA_W-1:0]    avg_out;
   logic signed [DATA_W-1:0]    min_out;
   logic signed [DATA_W-1:0]    max_out;
   logic        [LOG2N:0]       cnt_out;
   logic                        partial;
   logic                        val_out;

   int checks   = 0;
   int failures = 0;

   mult_add_win_stats #(.DATA_W(DATA_W), .LOG2N(LOG2N)) dut (
      .clk     (clk),
      .rst     (rst),
      .din     (din),
      .din_val (din_val),
      .flush   (flush),
      .sum_out (sum_out),
      .avg_out (avg_out),
      .min_out (min_out),
      .max_out (max_out),
      .cnt_out (cnt_out),
      .partial (partial),
      .val_out (val_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive one edge's inputs, then sample just after that edge.
   task automatic step(input logic v, input int d, input logic f, input logic r);
      din     = DATA_W'(d);
      din_val = v;
      flush   = f;
      rst     = r;
      @(posedge clk);
      #1;
   endtask

   task automatic check_win(input string tag, input int s, input int a, input int mn,
                            input int mx, input int c, input int p);
      check({tag, ".val"},  int'(val_out), 1);
      check({tag, ".sum"},  int'(sum_out), s);
      check({tag, ".avg"},  int'(avg_out), a);
      check({tag, ".min"},  int'(min_out), mn);
      check({tag, ".max"},  int'(max_out), mx);
      check({tag, ".cnt"},  int'(cnt_out), c);
      check({tag, ".part"}, int'(partial), p);
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".val"},  int'(val_out), 0);
      check({tag, ".sum"},  int'(sum_out), 0);
      check({tag, ".avg"},  int'(avg_out), 0);
      check({tag, ".min"},  int'(min_out), 0);
      check({tag, ".max"},  int'(max_out), 0);
      check({tag, ".cnt"},  int'(cnt_out), 0);
      check({tag, ".part"}, int'(partial), 0);
   endtask

   initial begin
      rst = 1'b1; din = '0; din_val = 1'b0; flush = 1'b0;
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      check_zero("reset");

      // Full window, back-to-back.
      step(1, 10, 0, 0);
      step(1, 20, 0, 0);
      step(1, 30, 0, 0);
      check("full.early_val", int'(val_out), 0);
      step(1, 40, 0, 0);
      check_win("full", 100, 25, 10, 40, 4, 0);

      // Next window starts on the very next edge; result regs hold, pulse drops.
      step(1, -1, 0, 0);
      check("pulse.val", int'(val_out), 0);
      check("hold.sum", int'(sum_out), 100);
      step(1, -1, 0, 0);
      step(1, -1, 0, 0);
      step(1, -2, 0, 0);
      check_win("negfloor", -5, -2, -2, -1, 4, 0);

      // Extremes.
      for (int i = 0; i < 4; i++) step(1, 127, 0, 0);
      check_win("maxpos", 508, 127, 127, 127, 4, 0);
      for (int i = 0; i < 4; i++) step(1, -128, 0, 0);
      check_win("maxneg", -512, -128, -128, -128, 4, 0);

      // Gapped input.
      step(1, 10, 0, 0);
      step(0, 99, 0, 0);
      check("gap.val", int'(val_out), 0);
      step(1, 20, 0, 0);
      step(0, 77, 0, 0);
      step(0, 55, 0, 0);
      step(1, 30, 0, 0);
      step(0, 0, 0, 0);
      step(1, 40, 0, 0);
      check_win("gapped", 100, 25, 10, 40, 4, 0);

      // Early flush after two samples.
      step(1, 8, 0, 0);
      step(1, 4, 0, 0);
      step(0, 0, 1, 0);
      check_win("flush2", 12, 3, 4, 8, 2, 1);
      step(0, 0, 0, 0);
      check("flush2.pulse", int'(val_out), 0);

      // Flush with the 4th sample is a normal full window.
      step(1, 1, 0, 0);
      step(1, 2, 0, 0);
      step(1, 3, 0, 0);
      step(1, 4, 1, 0);
      check_win("flush4", 10, 2, 1, 4, 4, 0);

      // Flush with empty window: nothing happens.
      step(0, 0, 1, 0);
      check("flush_empty.val", int'(val_out), 0);
      check("flush_empty.sum", int'(sum_out), 10);
      step(0, 0, 1, 0);
      check("flush_empty2.val", int'(val_out), 0);

      // Flush held high: each sample is its own partial window.
      step(1, 5, 1, 0);
      check_win("flushheld1", 5, 1, 5, 5, 1, 1);
      step(1, -3, 1, 0);
      check_win("flushheld2", -3, -1, -3, -3, 1, 1);
      step(0, 0, 0, 0);

      // Reset mid-window, with a sample and flush present on the reset edge.
      step(1, 50, 0, 0);
      step(1, 50, 0, 0);
      step(1, 50, 0, 0);
      step(1, 99, 1, 1);
      check_zero("midreset");
      step(1, 1, 0, 0);
      step(1, 2, 0, 0);
      step(1, 3, 0, 0);
      check("postreset.early_val", int'(val_out), 0);
      step(1, 4, 0, 0);
      check_win("postreset", 10, 2, 1, 4, 4, 0);
      step(0, 0, 0, 0);
      check("postreset.pulse", int'(val_out), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mult_add_win_stats.md
Name: mult_add_win_stats

Overview:
- Downstream stage of the signed 8-bit multiply-add pipeline. It consumes that stage's result stream: `s` goes to `din` and `rdy_out` goes to `din_val`.
- Groups accepted samples into windows of 2^LOG2N and reports per-window sum, mean, min and max with a one-cycle valid pulse.
- A flush input closes a window early and marks the result as partial.
- Feeds the result/logging path of the datapath.

Parameters:
- DATA_W, 8: sample width, signed two's complement.
- LOG2N, 3: log2 of the window length. Legal range 1..6. Window length N = 2^LOG2N.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- din  in  DATA_W  signed sample from the multiply-add stage.
- din_val  in  1  sample qualifier; `din` is accepted on every edge where this is 1.
- flush  in  1  close the current window early; level-sampled on each edge.
- sum_out  out  DATA_W+LOG2N  signed window sum.
- avg_out  out  DATA_W  signed mean.
- min_out  out  DATA_W  signed minimum of the window.
- max_out  out  DATA_W  signed maximum of the window.
- cnt_out  out  LOG2N+1  number of samples in the reported window, 1..N.
- partial  out  1  1 when the window was closed by `flush` with fewer than N samples.
- val_out  out  1  one-cycle pulse; all result outputs are valid while it is 1.

Behaviour:
- One clock, `clk`. Reset is synchronous and active-high on `rst`.
- Reset values:
  - All outputs are 0. `min_out`/`max_out` are also 0.
  - Internal accumulator 0, count 0, running min 127 (+max), running max -128 (-max).
- Reset mid-window discards the partial window. There is no output for it.
- State:
  - Accumulator `acc`, width DATA_W+LOG2N. It is never able to overflow: N*(-128) .. N*127 fits.
  - Count `cnt`, width LOG2N+1.
  - Running `mn` and `mx`.
  - No explicit FSM beyond the counter. The block is either idle (`cnt`=0) or filling (1..N-1).
- Accept, on an edge with `din_val`=1:
  - nxt_acc = acc + sign-extended `din`.
  - nxt_cnt = cnt + 1.
  - nxt_mn = min(mn, din); nxt_mx = max(mx, din). Comparisons are signed.
- Close condition, on an edge where either holds:
  - (a) `din_val`=1 and cnt = N-1 (full window), or
  - (b) `flush`=1 and nxt_cnt > 0 (partial, or full if case (a) also holds).
- On close:
  - Output registers load from the nxt_* values.
  - `avg_out` = nxt_acc >>> LOG2N: arithmetic shift, truncation toward -inf, no rounding. A partial window is still divided by N.
  - `cnt_out` = nxt_cnt.
  - `partial` = (nxt_cnt < N).
  - `val_out` = 1 for exactly the next cycle.
  - Internal state returns to its reset values on the same edge.
- Latency: results appear one cycle after the closing edge.
- Back-to-back:
  - `din_val`=1 every cycle is supported with no bubble. The sample on the edge after a close starts the new window.
- Gaps: cycles with `din_val`=0 are ignored; no state change.
- Flush with nxt_cnt = 0 (empty window, no sample): no output, no state change.
- Flush together with the N-th sample: this is a normal full window, with `partial`=0.
- `flush` held high continuously: every accepted sample closes a 1-sample partial window.
- When no window closes, output registers hold their last values and `val_out`=0.
- `rst` has priority over `din_val` and `flush` on the same edge.

Decomposition:
- Shared package mult_add_pkg holds:
  - DATA_W = 8;
  - constants SMIN = -128 and SMAX = 127;
  - a sum-width function DATA_W+LOG2N.
  - The multiply-add stage uses it too.
- One sub-module, win_minmax: running signed min/max registers with clear and update enables. It is reused by other stats blocks.
- Accumulator, counter and output registers stay in the top module.

Test Plan (LOG2N=2, N=4):
- Full window, back-to-back:
  - Stimulus: `din` = 10, 20, 30, 40 on consecutive edges with `din_val`=1.
  - Response: `val_out` one cycle after the 4th edge; sum 100, avg 25, min 10, max 40, cnt 4, partial 0.
  - Next sample starts a new window with no gap.
- Negative floor rounding:
  - Stimulus: -1, -1, -1, -2.
  - Response: sum -5, avg -2, min -2, max -1.
- Extremes:
  - Stimulus: 127 x4, then -128 x4.
  - Response: sum 508 / avg 127, then sum -512 / avg -128. No wrap.
- Gapped input and early flush:
  - Gapped: 10, 20, 30, 40 with idle cycles between them gives the same result as the back-to-back case.
  - Early flush: after samples 8 and 4, `flush`=1 alone gives sum 12, avg 3, min 4, max 8, cnt 2, partial 1.
- Flush corner cases:
  - Flush on the edge carrying the 4th sample: full result, partial 0.
  - Flush with an empty window: no `val_out`.
- Reset mid-window:
  - Stimulus: 3 samples of 50, `rst` for 1 cycle, then 1, 2, 3, 4.
  - Response: single result with sum 10, avg 2, min 1, max 4. All outputs 0 during reset.
